// File: rtl/vj_detection_buffer.sv
// vj_detection_buffer
// Takes detection strobes from the Viola-Jones cascade, rescales the window
// coordinates from pyramid-level pixels to original-image pixels, queues the
// results in a show-ahead FIFO and drains them over a valid/ready handshake.
// Per-frame accept/drop counters and a sticky overflow flag are maintained.
module vj_detection_buffer #(
  parameter int unsigned       DEPTH       = 16,
  parameter int unsigned       WINDOW_SIZE = 24,
  parameter logic [15:0][15:0] SCALE_TABLE = {
    16'h04C0, 16'h0480, 16'h0440, 16'h0400,
    16'h03C0, 16'h0380, 16'h0340, 16'h0300,
    16'h02C0, 16'h0280, 16'h0240, 16'h0200,
    16'h01C0, 16'h0180, 16'h0140, 16'h0100
  }
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0][31:0] top_left,
  input  logic             top_left_ready,
  input  logic [3:0]       pyramid_number,
  input  logic             frame_start,
  output logic             det_valid,
  input  logic             det_ready,
  output logic [15:0]      det_x,
  output logic [15:0]      det_y,
  output logic [15:0]      det_size,
  output logic [3:0]       det_level,
  output logic [15:0]      det_count,
  output logic [15:0]      drop_count,
  output logic             overflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [15:0] WIN = 16'(WINDOW_SIZE);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] size;
    logic [3:0]  level;
  } entry_t;

  // Q8.8 rescale: 16x16 unsigned product, floor by dropping 8 fraction bits,
  // saturating when the integer part no longer fits in 16 bits.
  function automatic logic [15:0] scale_coord(input logic [15:0] v, input logic [15:0] s);
    logic [31:0] prod;
    prod = {16'd0, v} * {16'd0, s};
    if (prod[31:24] != 8'd0) begin
      return 16'hFFFF;
    end else begin
      return prod[23:8];
    end
  endfunction

  // Only the low 16 bits of each coordinate are meaningful.
  logic unused_top_bits_s;
  assign unused_top_bits_s = ^{top_left[1][31:16], top_left[0][31:16]};

  // Flush request shared by reset and frame_start (both clear queue and pipeline).
  logic flush_s;
  assign flush_s = reset | frame_start;

  // ---------------- S1: capture ----------------
  logic        s1_valid_q;
  logic [15:0] s1_x_q;
  logic [15:0] s1_y_q;
  logic [3:0]  s1_level_q;

  // Capture stage register; flush discards a coincident strobe.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= 16'd0;
      s1_y_q     <= 16'd0;
      s1_level_q <= 4'd0;
    end else begin
      s1_valid_q <= top_left_ready;
      if (top_left_ready) begin
        s1_x_q     <= top_left[0][15:0];
        s1_y_q     <= top_left[1][15:0];
        s1_level_q <= pyramid_number;
      end
    end
  end

  // ---------------- S2: scale ----------------
  logic        s2_valid_q;
  entry_t      s2_entry_q;
  entry_t      s2_entry_d;
  logic [15:0] scale_s;

  assign scale_s = SCALE_TABLE[s1_level_q];

  // Scaled entry computed from the captured coordinates.
  always_comb begin
    s2_entry_d       = '0;
    s2_entry_d.x     = scale_coord(s1_x_q, scale_s);
    s2_entry_d.y     = scale_coord(s1_y_q, scale_s);
    s2_entry_d.size  = scale_coord(WIN, scale_s);
    s2_entry_d.level = s1_level_q;
  end

  // Scale stage register; in-flight work is dropped silently on flush.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      s2_valid_q <= 1'b0;
      s2_entry_q <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_entry_q <= s2_entry_d;
      end
    end
  end

  // ---------------- FIFO ----------------
  entry_t      mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        valid_q, valid_d;
  entry_t      head_q, head_d;
  logic [15:0] det_count_q, det_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic        overflow_q, overflow_d;

  logic empty_s, full_s, pop_s, push_s, drop_s;

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s   = !empty_s && det_ready;
  assign push_s  = s2_valid_q && (!full_s || pop_s);
  assign drop_s  = s2_valid_q && !push_s;

  // Next pointers, counters and registered head-of-queue view.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    valid_d      = valid_q;
    head_d       = head_q;
    det_count_d  = det_count_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    if (frame_start) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      valid_d      = 1'b0;
      det_count_d  = 16'd0;
      drop_count_d = 16'd0;
      overflow_d   = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (det_count_q != 16'hFFFF) begin
          det_count_d = det_count_q + 16'd1;
        end
      end else if (drop_s) begin
        overflow_d = 1'b1;
        if (drop_count_q != 16'hFFFF) begin
          drop_count_d = drop_count_q + 16'd1;
        end
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      valid_d = (wr_ptr_d != rd_ptr_d);
      // The new entry becomes the head when it lands in the slot the read
      // pointer will point at (write into empty, or push+pop at one entry).
      if (push_s && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
        head_d = s2_entry_q;
      end else if (valid_d) begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end else begin
        head_d = head_q;
      end
    end
  end

  // FIFO storage write; data contents need no reset.
  always_ff @(posedge clock) begin
    if (!flush_s && push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s2_entry_q;
    end
  end

  // Pointer, counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      valid_q      <= 1'b0;
      head_q       <= '0;
      det_count_q  <= 16'd0;
      drop_count_q <= 16'd0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      valid_q      <= valid_d;
      head_q       <= head_d;
      det_count_q  <= det_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign det_valid  = valid_q;
  assign det_x      = head_q.x;
  assign det_y      = head_q.y;
  assign det_size   = head_q.size;
  assign det_level  = head_q.level;
  assign det_count  = det_count_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_vj_detection_buffer.sv
// Directed testbench for vj_detection_buffer with a scoreboard queue:
// expected entries are pushed when a strobe is driven and compared when the
// DUT hands the head entry over the valid/ready handshake.
module tb_vj_detection_buffer;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] size;
    logic [3:0]  level;
  } ent_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0][31:0] top_left;
  logic             top_left_ready;
  logic [3:0]       pyramid_number;
  logic             frame_start;
  logic             det_valid;
  logic             det_ready;
  logic [15:0]      det_x, det_y, det_size;
  logic [3:0]       det_level;
  logic [15:0]      det_count, drop_count;
  logic             overflow;

  int   compared   = 0;
  int   mismatched = 0;
  int   npop       = 0;
  ent_t exp_q[$];

  always #5 clock = ~clock;

  vj_detection_buffer #(.DEPTH(16), .WINDOW_SIZE(24)) dut (
    .clock          (clock),
    .reset          (reset),
    .top_left       (top_left),
    .top_left_ready (top_left_ready),
    .pyramid_number (pyramid_number),
    .frame_start    (frame_start),
    .det_valid      (det_valid),
    .det_ready      (det_ready),
    .det_x          (det_x),
    .det_y          (det_y),
    .det_size       (det_size),
    .det_level      (det_level),
    .det_count      (det_count),
    .drop_count     (drop_count),
    .overflow       (overflow)
  );

  // Reference rescale: scale = 1.0 + 0.25*level, floor, clamp at 0xFFFF.
  function automatic logic [15:0] mdl(input int unsigned v, input int unsigned lvl);
    longint unsigned q;
    logic [15:0] r;
    q = (longint'(v) * longint'(256 + 64 * lvl)) / 256;
    if (q > 65535) r = 16'hFFFF;
    else begin
      r = 16'(q);
    end
    return r;
  endfunction

  function automatic ent_t model_entry(input int unsigned x, input int unsigned y, input int unsigned lvl);
    ent_t e;
    e.x     = mdl(x, lvl);
    e.y     = mdl(y, lvl);
    e.size  = mdl(24, lvl);
    e.level = 4'(lvl);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle; inputs are already set. If the head is handed over on
  // the coming edge, compare it against the scoreboard first.
  task automatic cycle();
    ent_t e;
    if (det_valid && det_ready && !frame_start && !reset) begin
      if (exp_q.size() == 0) begin
        check("unexpected_entry", {16'd0, det_x}, 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("sb_x", {16'd0, det_x}, {16'd0, e.x});
        check("sb_y", {16'd0, det_y}, {16'd0, e.y});
        check("sb_size", {16'd0, det_size}, {16'd0, e.size});
        check("sb_level", {28'd0, det_level}, {28'd0, e.level});
      end
      npop++;
    end
    @(posedge clock);
    @(negedge clock);
    if (frame_start || reset) exp_q.delete();
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [3:0] lvl, input bit expect_push);
    top_left[0]    = x;
    top_left[1]    = y;
    pyramid_number = lvl;
    top_left_ready = 1'b1;
    if (expect_push) exp_q.push_back(model_entry(int'(x[15:0]), int'(y[15:0]), int'(lvl)));
    cycle();
    top_left_ready = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    det_ready = 1'b1;
    while ((exp_q.size() != 0 || det_valid) && n < bound) begin
      cycle();
      n++;
    end
    check("drain_done", {31'd0, (exp_q.size() == 0 && !det_valid)}, 32'd1);
    det_ready = 1'b0;
  endtask

  task automatic new_frame();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  initial begin
    int p0;
    reset = 1'b1; frame_start = 1'b0; top_left_ready = 1'b0; det_ready = 1'b0;
    top_left = '0; pyramid_number = 4'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst_valid", {31'd0, det_valid}, 32'd0);
    check("rst_x", {16'd0, det_x}, 32'd0);
    check("rst_y", {16'd0, det_y}, 32'd0);
    check("rst_size", {16'd0, det_size}, 32'd0);
    check("rst_level", {28'd0, det_level}, 32'd0);
    check("rst_det_count", {16'd0, det_count}, 32'd0);
    check("rst_drop_count", {16'd0, drop_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    // Single detection at level 1, 3-cycle latency
    drive(32'd40, 32'd16, 4'd1, 1'b1);
    check("lat_e0_valid", {31'd0, det_valid}, 32'd0);
    cycle();
    check("lat_e1_valid", {31'd0, det_valid}, 32'd0);
    cycle();
    check("lat_e2_valid", {31'd0, det_valid}, 32'd1);
    check("single_x", {16'd0, det_x}, 32'd50);
    check("single_y", {16'd0, det_y}, 32'd20);
    check("single_size", {16'd0, det_size}, 32'd30);
    check("single_level", {28'd0, det_level}, 32'd1);
    check("single_count", {16'd0, det_count}, 32'd1);
    drain(20);

    // Level 0 identity, level 1 floor
    drive(32'd7, 32'd9, 4'd0, 1'b1);
    drive(32'd3, 32'd5, 4'd1, 1'b1);
    cycle();
    check("l0_x", {16'd0, det_x}, 32'd7);
    check("l0_y", {16'd0, det_y}, 32'd9);
    check("l0_size", {16'd0, det_size}, 32'd24);
    drain(20);

    // Overflow: 20 strobes into a stalled 16-deep FIFO
    new_frame();
    for (int i = 0; i < 20; i++) drive(32'(10 + 5 * i), 32'(100 + i), 4'(i), i < 16);
    cycle();
    cycle();
    check("ovf_det_count", {16'd0, det_count}, 32'd16);
    check("ovf_drop_count", {16'd0, drop_count}, 32'd4);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    drain(60);

    // frame_start with in-flight detections and a coincident strobe
    drive(32'd11, 32'd12, 4'd2, 1'b1);
    drive(32'd13, 32'd14, 4'd3, 1'b1);
    top_left[0] = 32'd15; top_left[1] = 32'd16; pyramid_number = 4'd4;
    top_left_ready = 1'b1;
    new_frame();
    top_left_ready = 1'b0;
    check("fs_valid", {31'd0, det_valid}, 32'd0);
    check("fs_det_count", {16'd0, det_count}, 32'd0);
    check("fs_drop_count", {16'd0, drop_count}, 32'd0);
    check("fs_overflow", {31'd0, overflow}, 32'd0);
    drive(32'd21, 32'd22, 4'd5, 1'b1);
    cycle();
    check("fs_next_e1_valid", {31'd0, det_valid}, 32'd0);
    cycle();
    check("fs_next_e2_valid", {31'd0, det_valid}, 32'd1);
    check("fs_next_count", {16'd0, det_count}, 32'd1);
    drain(20);

    // Full FIFO with simultaneous pop, pointers wrap
    new_frame();
    p0 = npop;
    for (int i = 0; i < 36; i++) begin
      det_ready = (i >= 18);
      if (i >= 18) check("full_occupancy", 32'(int'(det_count) - (npop - p0)), 32'd16);
      drive(32'(200 + 7 * i), 32'(300 + 3 * i), 4'(i % 5), 1'b1);
    end
    check("full_drop_count", {16'd0, drop_count}, 32'd0);
    drain(80);
    check("full_det_count", {16'd0, det_count}, 32'd36);
    check("full_overflow", {31'd0, overflow}, 32'd0);

    // Saturation at level 15, upper coordinate bits ignored
    new_frame();
    drive(32'hABCD_FFFF, 32'h1234_0002, 4'd15, 1'b1);
    cycle();
    cycle();
    check("sat_x", {16'd0, det_x}, 32'h0000_FFFF);
    check("sat_y", {16'd0, det_y}, 32'd9);
    check("sat_size", {16'd0, det_size}, 32'd114);
    drain(20);

    // Reset in the middle of a burst
    for (int i = 0; i < 5; i++) drive(32'(i), 32'(i), 4'd0, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_mid_valid", {31'd0, det_valid}, 32'd0);
    check("rst_mid_x", {16'd0, det_x}, 32'd0);
    check("rst_mid_det_count", {16'd0, det_count}, 32'd0);
    repeat (4) cycle();
    check("rst_mid_valid_later", {31'd0, det_valid}, 32'd0);
    check("rst_mid_drop_count", {16'd0, drop_count}, 32'd0);
    check("rst_mid_det_count_later", {16'd0, det_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
